load_store_queue: RTL and testbench

Parametrised in-order load/store queue for the Tomasulo RISC-V core, sitting between dispatch, the common data bus (CDB), the ROB commit port and the memory controller. It holds up to `DEPTH` memory ops and captures base/data operands by snooping the CDB. It issues one memory transaction at a time from the head, with byte/half/word sizing and load sign/zero extension. Stores are held until ROB commit, and a flush discards speculative entries.

---
 rtl/lsq_pkg.sv | 30 +++
 rtl/lsq_load_ext.sv | 31 +++
 rtl/load_store_queue.sv | 230 +++++++++++++++++++++++
 tb/tb_load_store_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// ============================================================================
//  Module  : lsq_pkg
//  Brief   : Op encodings, size codes and FSM state type for the load/store queue
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsq_pkg;

   localparam logic [3:0] c_OP_LB  = 4'b0000;
   localparam logic [3:0] c_OP_LH  = 4'b0001;
   localparam logic [3:0] c_OP_LW  = 4'b0010;
   localparam logic [3:0] c_OP_LBU = 4'b0100;
   localparam logic [3:0] c_OP_LHU = 4'b0101;
   localparam logic [3:0] c_OP_SB  = 4'b1000;
   localparam logic [3:0] c_OP_SH  = 4'b1001;
   localparam logic [3:0] c_OP_SW  = 4'b1010;

   localparam logic [1:0] c_SIZE_BYTE = 2'd0;
   localparam logic [1:0] c_SIZE_HALF = 2'd1;
   localparam logic [1:0] c_SIZE_WORD = 2'd2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } lsq_state_t;

endpackage

`default_nettype wire

// File: rtl/lsq_load_ext.sv
// ============================================================================
//  Module  : lsq_load_ext
//  Brief   : Combinational load data sign/zero extension by funct3
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsq_load_ext
   import lsq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] ext
);

   always_comb begin
      ext = raw;
      case (funct3)
         c_OP_LB[2:0]:  ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
         c_OP_LH[2:0]:  ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
         c_OP_LBU[2:0]: ext = {{(XLEN-8){1'b0}}, raw[7:0]};
         c_OP_LHU[2:0]: ext = {{(XLEN-16){1'b0}}, raw[15:0]};
         default:       ext = raw;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_queue.sv
// ============================================================================
//  Module  : load_store_queue
//  Brief   : In-order LSQ with CDB snooping, commit-gated stores and flush
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_queue
   import lsq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic [3:0]       disp_op,
   input  logic [TAG_W-1:0] disp_tag,
   input  logic [XLEN-1:0]  disp_imm,
   input  logic             disp_base_rdy,
   input  logic [XLEN-1:0]  disp_base,
   input  logic [TAG_W-1:0] disp_base_q,
   input  logic             disp_data_rdy,
   input  logic [XLEN-1:0]  disp_data,
   input  logic [TAG_W-1:0] disp_data_q,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_value,
   input  logic             commit_valid,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic             flush,
   output logic             mem_req,
   output logic             mem_we,
   output logic [1:0]       mem_size,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_wdata,
   input  logic             mem_done,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             res_valid,
   output logic [TAG_W-1:0] res_tag,
   output logic [XLEN-1:0]  res_value
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0] r_valid, r_base_rdy, r_data_rdy, r_committed;
   logic [3:0]       r_op       [DEPTH];
   logic [TAG_W-1:0] r_tag      [DEPTH];
   logic [TAG_W-1:0] r_base_q   [DEPTH];
   logic [TAG_W-1:0] r_data_q   [DEPTH];
   logic [XLEN-1:0]  r_imm      [DEPTH];
   logic [XLEN-1:0]  r_base_val [DEPTH];
   logic [XLEN-1:0]  r_data_val [DEPTH];

   logic [PTR_W-1:0] r_head, r_tail;
   logic [CNT_W-1:0] r_count;
   lsq_state_t       r_state, w_state_nxt;
   logic             r_kill;

   logic             w_push, w_pop, w_launch, w_head_ok, w_run;
   logic             w_base_fwd, w_data_fwd;
   logic [DEPTH-1:0] w_base_snoop, w_data_snoop, w_committed_eff, w_in_keep;
   logic [CNT_W-1:0] w_keep;
   logic [3:0]       w_head_op;
   logic [XLEN-1:0]  w_ext;

   assign disp_ready = (r_count != CNT_W'(DEPTH));
   assign w_push     = disp_valid && disp_ready && !flush;
   assign w_head_op  = r_op[r_head];
   assign w_head_ok  = r_valid[r_head] && r_base_rdy[r_head] &&
                       (!w_head_op[3] || (r_data_rdy[r_head] && r_committed[r_head]));
   assign w_base_fwd = cdb_valid && !disp_base_rdy && (disp_base_q == cdb_tag);
   assign w_data_fwd = cdb_valid && !disp_data_rdy && (disp_data_q == cdb_tag);

   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         w_base_snoop[j]    = cdb_valid && r_valid[j] && !r_base_rdy[j] && (r_base_q[j] == cdb_tag);
         w_data_snoop[j]    = cdb_valid && r_valid[j] && !r_data_rdy[j] && (r_data_q[j] == cdb_tag);
         w_committed_eff[j] = r_committed[j] ||
                              (commit_valid && r_valid[j] && r_op[j][3] && (r_tag[j] == commit_tag));
      end
   end

   // Survivors of a flush: the in-flight head (it must still pop) plus the committed prefix.
   always_comb begin
      w_keep    = '0;
      w_in_keep = '0;
      w_run     = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_run && (((i == 0) && (r_state == ST_BUSY)) ||
                       (r_valid[r_head + PTR_W'(i)] && w_committed_eff[r_head + PTR_W'(i)]))) begin
            w_keep                         = w_keep + CNT_W'(1);
            w_in_keep[r_head + PTR_W'(i)]  = 1'b1;
         end else begin
            w_run = 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: if (w_head_ok && !flush) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_BUSY;
         end
         ST_BUSY: if (mem_done) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_IDLE;
      else if (rdy)
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid     <= '0;
         r_base_rdy  <= '0;
         r_data_rdy  <= '0;
         r_committed <= '0;
         for (int j = 0; j < DEPTH; j++) begin
            r_op[j]       <= '0;
            r_tag[j]      <= '0;
            r_base_q[j]   <= '0;
            r_data_q[j]   <= '0;
            r_imm[j]      <= '0;
            r_base_val[j] <= '0;
            r_data_val[j] <= '0;
         end
      end else if (rdy) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (w_push && (r_tail == PTR_W'(j))) begin
               r_valid[j]     <= 1'b1;
               r_op[j]        <= disp_op;
               r_tag[j]       <= disp_tag;
               r_imm[j]       <= disp_imm;
               r_base_rdy[j]  <= disp_base_rdy || w_base_fwd;
               r_base_val[j]  <= disp_base_rdy ? disp_base : cdb_value;
               r_base_q[j]    <= disp_base_q;
               r_data_rdy[j]  <= disp_data_rdy || w_data_fwd;
               r_data_val[j]  <= disp_data_rdy ? disp_data : cdb_value;
               r_data_q[j]    <= disp_data_q;
               r_committed[j] <= 1'b0;
            end else begin
               if ((w_pop && (r_head == PTR_W'(j))) || (flush && !w_in_keep[j]))
                  r_valid[j] <= 1'b0;
               if (w_base_snoop[j]) begin
                  r_base_rdy[j] <= 1'b1;
                  r_base_val[j] <= cdb_value;
               end
               if (w_data_snoop[j]) begin
                  r_data_rdy[j] <= 1'b1;
                  r_data_val[j] <= cdb_value;
               end
               r_committed[j] <= w_committed_eff[j];
            end
         end
      end
   end

   lsq_load_ext #(.XLEN(XLEN)) u_load_ext (
      .funct3 (w_head_op[2:0]),
      .raw    (mem_rdata),
      .ext    (w_ext)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_kill    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_size  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         res_valid <= 1'b0;
         res_tag   <= '0;
         res_value <= '0;
      end else if (rdy) begin
         r_head <= r_head + PTR_W'(w_pop);
         if (flush) begin
            r_tail  <= r_head + w_keep[PTR_W-1:0];
            r_count <= w_keep - CNT_W'(w_pop);
         end else begin
            r_tail  <= r_tail + PTR_W'(w_push);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         end

         // A flushed in-flight load still completes but must not broadcast.
         if (w_pop)
            r_kill <= 1'b0;
         else if (flush && (r_state == ST_BUSY) && !w_head_op[3])
            r_kill <= 1'b1;

         if (w_launch) begin
            mem_req   <= 1'b1;
            mem_we    <= w_head_op[3];
            mem_size  <= w_head_op[1:0];
            mem_addr  <= r_base_val[r_head] + r_imm[r_head];
            mem_wdata <= r_data_val[r_head];
         end else if (w_pop) begin
            mem_req <= 1'b0;
         end

         res_valid <= w_pop && !w_head_op[3] && !r_kill && !flush;
         if (w_pop && !w_head_op[3] && !r_kill && !flush) begin
            res_tag   <= r_tag[r_head];
            res_value <= w_ext;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_load_store_queue.sv
// ============================================================================
//  Module  : tb_load_store_queue
//  Brief   : Self-checking bench for load_store_queue with a result scoreboard
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_queue;

   localparam int DEPTH = 16;
   localparam int TAG_W = 4;
   localparam int XLEN  = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rdy = 1'b1;
   logic             disp_valid = 1'b0;
   logic             disp_ready;
   logic [3:0]       disp_op = '0;
   logic [TAG_W-1:0] disp_tag = '0;
   logic [XLEN-1:0]  disp_imm = '0;
   logic             disp_base_rdy = 1'b0;
   logic [XLEN-1:0]  disp_base = '0;
   logic [TAG_W-1:0] disp_base_q = '0;
   logic             disp_data_rdy = 1'b0;
   logic [XLEN-1:0]  disp_data = '0;
   logic [TAG_W-1:0] disp_data_q = '0;
   logic             cdb_valid = 1'b0;
   logic [TAG_W-1:0] cdb_tag = '0;
   logic [XLEN-1:0]  cdb_value = '0;
   logic             commit_valid = 1'b0;
   logic [TAG_W-1:0] commit_tag = '0;
   logic             flush = 1'b0;
   logic             mem_req, mem_we;
   logic [1:0]       mem_size;
   logic [XLEN-1:0]  mem_addr, mem_wdata;
   logic             mem_done = 1'b0;
   logic [XLEN-1:0]  mem_rdata = '0;
   logic             res_valid;
   logic [TAG_W-1:0] res_tag;
   logic [XLEN-1:0]  res_value;

   int n_checks = 0;
   int n_fail   = 0;

   logic [TAG_W-1:0] exp_tag_q [$];
   logic [XLEN-1:0]  exp_val_q [$];

   load_store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_tag(disp_tag), .disp_imm(disp_imm),
      .disp_base_rdy(disp_base_rdy), .disp_base(disp_base), .disp_base_q(disp_base_q),
      .disp_data_rdy(disp_data_rdy), .disp_data(disp_data), .disp_data_q(disp_data_q),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .res_valid(res_valid), .res_tag(res_tag), .res_value(res_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b100:  return {24'h0, raw[7:0]};
         3'b101:  return {16'h0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input logic [3:0] op, input logic [TAG_W-1:0] tag, input logic [31:0] imm,
                           input logic brdy, input logic [31:0] base, input logic [TAG_W-1:0] bq,
                           input logic drdy, input logic [31:0] data);
      disp_valid = 1'b1; disp_op = op; disp_tag = tag; disp_imm = imm;
      disp_base_rdy = brdy; disp_base = base; disp_base_q = bq;
      disp_data_rdy = drdy; disp_data = data; disp_data_q = '0;
      tick();
      disp_valid = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!mem_req && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_req"}, {31'h0, mem_req}, 32'h1);
   endtask

   task automatic complete(input logic [31:0] rdata);
      mem_done  = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_done  = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic run_load(input string tag, input logic [3:0] op, input logic [TAG_W-1:0] rtag,
                           input logic [31:0] base, input logic [31:0] rdata);
      dispatch(op, rtag, 32'h0, 1'b1, base, '0, 1'b0, 32'h0);
      wait_req(tag);
      check({tag, "_size"}, {30'h0, mem_size}, {30'h0, op[1:0]});
      exp_tag_q.push_back(rtag);
      exp_val_q.push_back(ext_model(op[2:0], rdata));
      complete(rdata);
      tick();
   endtask

   // Result monitor: every res_valid pulse must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (rst && res_valid) begin
         if (exp_tag_q.size() == 0) begin
            check("res_unexpected", 32'h1, 32'h0);
         end else begin
            check("res_tag", {28'h0, res_tag}, {28'h0, exp_tag_q.pop_front()});
            check("res_value", res_value, exp_val_q.pop_front());
         end
      end
   end

   initial begin
      #1;
      check("rst_disp_ready", {31'h0, disp_ready}, 32'h1);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_res_valid", {31'h0, res_valid}, 32'h0);
      check("rst_res_value", res_value, 32'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // LW into an empty queue
      dispatch(4'b0010, 4'd1, 32'h4, 1'b1, 32'h100, '0, 1'b0, 32'h0);
      check("lw_no_req_yet", {31'h0, mem_req}, 32'h0);
      tick();
      check("lw_req", {31'h0, mem_req}, 32'h1);
      check("lw_addr", mem_addr, 32'h104);
      check("lw_size", {30'h0, mem_size}, 32'h2);
      check("lw_we", {31'h0, mem_we}, 32'h0);
      tick();
      check("lw_hold_req", {31'h0, mem_req}, 32'h1);
      check("lw_hold_addr", mem_addr, 32'h104);
      exp_tag_q.push_back(4'd1);
      exp_val_q.push_back(32'hDEADBEEF);
      complete(32'hDEADBEEF);
      check("lw_req_drop", {31'h0, mem_req}, 32'h0);
      tick();

      // Extension variants
      run_load("lb",  4'b0000, 4'd2, 32'h10, 32'h12345680);
      run_load("lbu", 4'b0100, 4'd3, 32'h11, 32'h00000080);
      run_load("lh",  4'b0001, 4'd4, 32'h12, 32'h00008001);
      run_load("lhu", 4'b0101, 4'd5, 32'h14, 32'hABCD8001);
      run_load("f3x", 4'b0011, 4'd6, 32'h18, 32'h8765F0F0);

      // Store waits for base then commit
      dispatch(4'b1010, 4'd7, 32'h8, 1'b0, 32'h0, 4'd3, 1'b1, 32'hCAFEF00D);
      repeat (3) tick();
      check("sw_wait_base", {31'h0, mem_req}, 32'h0);
      cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h200;
      tick();
      cdb_valid = 1'b0;
      repeat (3) tick();
      check("sw_wait_commit", {31'h0, mem_req}, 32'h0);
      commit_valid = 1'b1; commit_tag = 4'd7;
      tick();
      commit_valid = 1'b0;
      wait_req("sw");
      check("sw_addr", mem_addr, 32'h208);
      check("sw_we", {31'h0, mem_we}, 32'h1);
      check("sw_wdata", mem_wdata, 32'hCAFEF00D);
      complete(32'h0);
      tick();

      // Full boundary
      for (int i = 0; i < DEPTH; i++)
         dispatch(4'b0010, 4'(i), 32'h0, 1'b0, 32'h0, 4'd9, 1'b0, 32'h0);
      check("full_ready", {31'h0, disp_ready}, 32'h0);
      check("full_count", {27'h0, dut.r_count}, DEPTH);
      dispatch(4'b0010, 4'd0, 32'h0, 1'b1, 32'h0, '0, 1'b0, 32'h0);
      check("full_reject", {27'h0, dut.r_count}, DEPTH);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_all_count", {27'h0, dut.r_count}, 32'h0);
      check("flush_all_ready", {31'h0, disp_ready}, 32'h1);

      // Flush keeps the committed store only
      dispatch(4'b1010, 4'd1, 32'h10, 1'b0, 32'h0, 4'd5, 1'b1, 32'h11223344);
      commit_valid = 1'b1; commit_tag = 4'd1;
      tick();
      commit_valid = 1'b0;
      dispatch(4'b0010, 4'd2, 32'h0, 1'b1, 32'h300, '0, 1'b0, 32'h0);
      dispatch(4'b1000, 4'd3, 32'h0, 1'b1, 32'h304, '0, 1'b1, 32'h55);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_count", {27'h0, dut.r_count}, 32'h1);
      cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'h400;
      tick();
      cdb_valid = 1'b0;
      wait_req("flush_sw");
      check("flush_sw_addr", mem_addr, 32'h410);
      check("flush_sw_we", {31'h0, mem_we}, 32'h1);
      complete(32'h0);
      repeat (5) tick();
      check("flush_idle_req", {31'h0, mem_req}, 32'h0);
      check("flush_empty", {27'h0, dut.r_count}, 32'h0);

      // Flush during an in-flight load
      dispatch(4'b0010, 4'd4, 32'h0, 1'b1, 32'h500, '0, 1'b0, 32'h0);
      wait_req("inflight");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("inflight_hold", {31'h0, mem_req}, 32'h1);
      complete(32'h12345678);
      check("inflight_drop", {31'h0, mem_req}, 32'h0);
      repeat (3) tick();
      check("inflight_empty", {27'h0, dut.r_count}, 32'h0);

      check("sb_drain", exp_tag_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
